// File: rtl/ae350_reset_sequencer.sv
// Reset and power-up sequencer for the AE350 SoC.
// Releases DDR3/PHY, CPU power-on and hardware resets in a fixed, counted
// order once the PLL is locked and the reset key is released. DDR3 bring-up
// is retried on timeout, and the sequence restarts whenever lock or the key
// is lost.
module ae350_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int DDR_RST_CYC = 1000,
  parameter int DDR_TIMEOUT = 5000000,
  parameter int POR_DELAY   = 256,
  parameter int HW_DELAY    = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_rstn_in,
  input  logic       pll_lock,
  input  logic       ddr3_init_done,
  output logic       ddr3_rstn,
  output logic       phy_rst_n,
  output logic       por_rstn,
  output logic       hw_rstn,
  output logic       sys_ready,
  output logic [2:0] state,
  output logic       ddr_timeout_err,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_DDR_RST   = 3'd2,
    S_WAIT_DDR  = 3'd3,
    S_POR_WAIT  = 3'd4,
    S_HW_WAIT   = 3'd5,
    S_RUN       = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_t;

  // Terminal counter values: a state held N cycles leaves when cnt == N-1.
  localparam logic [23:0] DDR_RST_LAST = 24'(DDR_RST_CYC - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(DDR_TIMEOUT - 1);
  localparam logic [23:0] POR_LAST     = 24'(POR_DELAY - 1);
  localparam logic [23:0] HW_LAST      = 24'(HW_DELAY - 1);

  logic [SYNC_STAGES-1:0] key_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] init_sync;
  logic                   key_s;
  logic                   lock_s;
  logic                   init_s;
  logic                   link_ok;

  state_t      cur_state;
  state_t      nxt_state;
  logic [23:0] cnt;
  logic        timeout_hit;
  logic        counting;

  logic        ddr_d;
  logic        por_d;
  logic        hw_d;
  logic        rdy_d;

  // Synchronize the three asynchronous inputs into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sync  <= '0;
      lock_sync <= '0;
      init_sync <= '0;
    end else begin
      key_sync  <= {key_sync[SYNC_STAGES-2:0],  key_rstn_in};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
      init_sync <= {init_sync[SYNC_STAGES-2:0], ddr3_init_done};
    end
  end

  assign key_s   = key_sync[SYNC_STAGES-1];
  assign lock_s  = lock_sync[SYNC_STAGES-1];
  assign init_s  = init_sync[SYNC_STAGES-1];
  // Lock and key must both be good for anything past WAIT_LOCK to continue.
  assign link_ok = key_s & lock_s;

  // Next-state logic: aborts are tested before counter completion.
  always_comb begin
    nxt_state   = cur_state;
    timeout_hit = 1'b0;
    unique case (cur_state)
      S_RESET: nxt_state = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (link_ok) nxt_state = S_DDR_RST;
      end
      S_DDR_RST: begin
        if (!link_ok)                nxt_state = S_WAIT_LOCK;
        else if (cnt == DDR_RST_LAST) nxt_state = S_WAIT_DDR;
      end
      S_WAIT_DDR: begin
        if (!link_ok) begin
          nxt_state = S_WAIT_LOCK;
        end else if (init_s) begin
          // Init arriving on the timeout cycle still wins.
          nxt_state = S_POR_WAIT;
        end else if (cnt == TIMEOUT_LAST) begin
          nxt_state   = S_DDR_RST;
          timeout_hit = 1'b1;
        end
      end
      S_POR_WAIT: begin
        if (!link_ok)            nxt_state = S_WAIT_LOCK;
        else if (!init_s)        nxt_state = S_WAIT_DDR;
        else if (cnt == POR_LAST) nxt_state = S_HW_WAIT;
      end
      S_HW_WAIT: begin
        if (!link_ok)           nxt_state = S_WAIT_LOCK;
        else if (!init_s)       nxt_state = S_WAIT_DDR;
        else if (cnt == HW_LAST) nxt_state = S_RUN;
      end
      S_RUN: begin
        if (!link_ok)     nxt_state = S_WAIT_LOCK;
        else if (!init_s) nxt_state = S_WAIT_DDR;
      end
      default: nxt_state = S_RESET;
    endcase
  end

  // Output decode from the next state so outputs move with the state edge.
  always_comb begin
    ddr_d = 1'b0;
    por_d = 1'b0;
    hw_d  = 1'b0;
    rdy_d = 1'b0;
    unique case (nxt_state)
      S_WAIT_DDR, S_POR_WAIT: ddr_d = 1'b1;
      S_HW_WAIT: begin
        ddr_d = 1'b1;
        por_d = 1'b1;
      end
      S_RUN: begin
        ddr_d = 1'b1;
        por_d = 1'b1;
        hw_d  = 1'b1;
        rdy_d = 1'b1;
      end
      default: begin
        ddr_d = 1'b0;
      end
    endcase
  end

  assign counting = (cur_state == S_DDR_RST)  || (cur_state == S_WAIT_DDR) ||
                    (cur_state == S_POR_WAIT) || (cur_state == S_HW_WAIT);

  // State register and the shared delay counter (cleared on state entry).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_RESET;
      cnt       <= '0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state) cnt <= '0;
      else if (counting)          cnt <= cnt + 24'd1;
      else                        cnt <= '0;
    end
  end

  // Registered reset outputs and ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr3_rstn <= 1'b0;
      phy_rst_n <= 1'b0;
      por_rstn  <= 1'b0;
      hw_rstn   <= 1'b0;
      sys_ready <= 1'b0;
    end else begin
      ddr3_rstn <= ddr_d;
      phy_rst_n <= ddr_d;
      por_rstn  <= por_d;
      hw_rstn   <= hw_d;
      sys_ready <= rdy_d;
    end
  end

  // Sticky DDR timeout flag and saturating retry counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr_timeout_err <= 1'b0;
      retry_cnt       <= 2'd0;
    end else if (timeout_hit) begin
      ddr_timeout_err <= 1'b1;
      if (retry_cnt != 2'd3) retry_cnt <= retry_cnt + 2'd1;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_ae350_reset_sequencer.sv
// Directed bench for ae350_reset_sequencer with short delays.
module tb_ae350_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       key_rstn_in;
  logic       pll_lock;
  logic       ddr3_init_done;
  logic       ddr3_rstn;
  logic       phy_rst_n;
  logic       por_rstn;
  logic       hw_rstn;
  logic       sys_ready;
  logic [2:0] state;
  logic       ddr_timeout_err;
  logic [1:0] retry_cnt;
  logic [4:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  ae350_reset_sequencer #(
    .SYNC_STAGES(2),
    .DDR_RST_CYC(8),
    .DDR_TIMEOUT(32),
    .POR_DELAY  (4),
    .HW_DELAY   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_rstn_in    (key_rstn_in),
    .pll_lock       (pll_lock),
    .ddr3_init_done (ddr3_init_done),
    .ddr3_rstn      (ddr3_rstn),
    .phy_rst_n      (phy_rst_n),
    .por_rstn       (por_rstn),
    .hw_rstn        (hw_rstn),
    .sys_ready      (sys_ready),
    .state          (state),
    .ddr_timeout_err(ddr_timeout_err),
    .retry_cnt      (retry_cnt)
  );

  // {ddr3_rstn, phy_rst_n, por_rstn, hw_rstn, sys_ready}
  assign outs = {ddr3_rstn, phy_rst_n, por_rstn, hw_rstn, sys_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [4:0] o);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_outs"},  32'(outs),  32'(o));
  endtask

  // Release ordering: hw implies por implies ddr, checked every cycle.
  always @(negedge clk) begin
    n_checks++;
    assert ((!hw_rstn || por_rstn) && (!por_rstn || ddr3_rstn)) else begin
      n_fail++;
      $error("FAIL order: observed ddr=%0b por=%0b hw=%0b expected monotonic release",
             ddr3_rstn, por_rstn, hw_rstn);
    end
  end

  initial begin
    rst            = 1'b1;
    key_rstn_in    = 1'b1;
    pll_lock       = 1'b1;
    ddr3_init_done = 1'b0;

    // Reset state.
    tick(3);
    chk_all("reset", 3'd0, 5'b00000);
    chk("reset_err",   32'(ddr_timeout_err), 32'd0);
    chk("reset_retry", 32'(retry_cnt),       32'd0);

    // Nominal power-up; edges counted from rst release (E1, E2, ...).
    rst = 1'b0;
    tick(1);  chk_all("e1_wait_lock", 3'd1, 5'b00000);
    tick(2);  chk_all("e3_ddr_rst",   3'd2, 5'b00000);
    tick(7);  chk_all("e10_ddr_rst",  3'd2, 5'b00000);
    tick(1);  chk_all("e11_wait_ddr", 3'd3, 5'b11000);
    tick(10); ddr3_init_done = 1'b1;             // after E21
    tick(6);  chk_all("e27_por_wait", 3'd4, 5'b11000);
    tick(1);  chk_all("e28_hw_wait",  3'd5, 5'b11100);
    tick(3);  chk_all("e31_hw_wait",  3'd5, 5'b11100);
    tick(1);  chk_all("e32_run",      3'd6, 5'b11111);

    // init_done drop in RUN, then hold it low through four timeouts.
    tick(2);  ddr3_init_done = 1'b0;             // after En
    tick(2);  chk_all("idrop_n2",     3'd6, 5'b11111);
    tick(1);  chk_all("idrop_n3",     3'd3, 5'b11000);
    chk("idrop_err", 32'(ddr_timeout_err), 32'd0);
    tick(31); chk_all("to1_before",   3'd3, 5'b11000);
    tick(1);  chk_all("to1_hit",      3'd2, 5'b00000);
    chk("to1_err",   32'(ddr_timeout_err), 32'd1);
    chk("to1_retry", 32'(retry_cnt),       32'd1);
    tick(7);  chk_all("to1_ddr_hold", 3'd2, 5'b00000);
    tick(1);  chk_all("to1_wait_ddr", 3'd3, 5'b11000);
    tick(32); chk_all("to2_hit",      3'd2, 5'b00000);
    chk("to2_retry", 32'(retry_cnt), 32'd2);
    tick(8);  chk_all("to2_wait_ddr", 3'd3, 5'b11000);
    tick(32); chk("to3_retry", 32'(retry_cnt), 32'd3);
    chk("to3_state", 32'(state), 32'd2);
    tick(8);
    tick(32); chk_all("to4_hit",      3'd2, 5'b00000);
    chk("to4_retry_sat", 32'(retry_cnt),       32'd3);
    chk("to4_err",       32'(ddr_timeout_err), 32'd1);
    tick(8);  chk_all("to4_wait_ddr", 3'd3, 5'b11000);

    // init returns: normal POR/HW release.
    ddr3_init_done = 1'b1;
    tick(3);  chk_all("irec_por_wait", 3'd4, 5'b11000);
    tick(4);  chk_all("irec_hw_wait",  3'd5, 5'b11100);
    tick(4);  chk_all("irec_run",      3'd6, 5'b11111);

    // One-cycle key press in RUN.
    tick(1);  key_rstn_in = 1'b0;                // after Ek
    tick(1);  key_rstn_in = 1'b1;
    tick(1);  chk_all("key_k2",        3'd6, 5'b11111);
    tick(1);  chk_all("key_k3",        3'd1, 5'b00000);
    chk("key_err",   32'(ddr_timeout_err), 32'd1);
    chk("key_retry", 32'(retry_cnt),       32'd3);
    tick(1);  chk_all("key_ddr_rst",   3'd2, 5'b00000);   // Ea

    // Lock loss with the DDR_RST counter at 5.
    tick(3);  pll_lock = 1'b0;                   // after Ea+3
    tick(2);  chk_all("lock_a5",       3'd2, 5'b00000);
    tick(1);  chk_all("lock_a6",       3'd1, 5'b00000);
    pll_lock = 1'b1;
    tick(2);  chk_all("lock_a8",       3'd1, 5'b00000);
    tick(1);  chk_all("lock_a9",       3'd2, 5'b00000);
    tick(7);  chk_all("lock_a16",      3'd2, 5'b00000);
    tick(1);  chk_all("lock_a17",      3'd3, 5'b11000);
    tick(1);  chk_all("lock_a18",      3'd4, 5'b11000);
    tick(4);  chk_all("lock_a22",      3'd5, 5'b11100);

    // Asynchronous reset mid HW_WAIT, away from any clock edge.
    tick(2);
    rst = 1'b1;
    #1;
    chk_all("arst", 3'd0, 5'b00000);
    chk("arst_err",   32'(ddr_timeout_err), 32'd0);
    chk("arst_retry", 32'(retry_cnt),       32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);  chk_all("rerun_wait_lock", 3'd1, 5'b00000);
    tick(2);  chk_all("rerun_ddr_rst",   3'd2, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
